// File: rtl/stream_framer_pkg.sv
// Purpose: shared types and helpers for the sample stream framer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package stream_framer_pkg;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } framer_state_t;

   // Marker fields of one FIFO entry. The sample data (TDATA_WIDTH bits) is
   // appended below these fields in the packed FIFO word, so the entry stays
   // generic in the data width: {first, last, data}.
   typedef struct packed {
      logic first;
      logic last;
   } fifo_entry_t;

   // Byte-rounded output width for a given sample width.
   function automatic int tdata_width(input int w);
      return 8 * ((w + 7) / 8);
   endfunction

endpackage

// File: rtl/sync_fifo_fwft_n.sv
// Purpose: generic synchronous FIFO with registered storage and occupancy output.
// Latency: a word written at edge n is readable on rd_data after that edge; no input-to-output bypass.
// Backpressure: writes while full are discarded; reads while empty are ignored.
// Ports: clk/rst (sync, active high); wr_en/wr_data/full; rd_en/rd_data/empty; level = occupancy.
module sync_fifo_fwft_n #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push;
   logic             pop;

   // Pointers carry one extra wrap bit: equal -> empty, only the wrap bit differs -> full.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push  = wr_en && !full;
   assign pop   = rd_en && !empty;

   // Masked while empty so the outputs read as zero instead of stale storage.
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/sample_stream_framer.sv
// Purpose: packs a free-running sample stream into AXI-Stream frames of FRAME_LEN samples.
// Latency: a sample written at cycle n appears on m_axis_* at n+1 when the FIFO was empty.
// Backpressure: never stalls the source; samples arriving with the FIFO full are dropped and flagged.
// Ports: clk, rst (sync, active high); enable (sampled at frame boundaries); s_data/s_valid source;
//        m_axis_tdata/tvalid/tready/tlast/tuser output stream; overflow (sticky); frame_count; fifo_level.
module sample_stream_framer
   import stream_framer_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAME_LEN  = 256,
   parameter int FIFO_DEPTH = 16,
   localparam int TDATA_WIDTH = tdata_width(DATA_WIDTH),
   localparam int LEVEL_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [DATA_WIDTH-1:0]  s_data,
   input  logic                   s_valid,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   output logic                   overflow,
   output logic [31:0]            frame_count,
   output logic [LEVEL_W-1:0]     fifo_level
);

   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   framer_state_t          state, state_nxt;
   logic [IDX_W-1:0]       idx, idx_nxt;
   logic                   wr_en;
   fifo_entry_t            wr_tag;
   fifo_entry_t            rd_tag;
   logic [TDATA_WIDTH-1:0] sext;
   logic [TDATA_WIDTH-1:0] rd_dat;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   out_fire;

   assign sext = TDATA_WIDTH'($signed(s_data));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // idx counts source samples, not accepted ones: a dropped sample still
   // consumes its slot so frames stay aligned to source time.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      wr_en     = 1'b0;
      wr_tag    = '0;
      case (state)
         S_IDLE: begin
            if (s_valid && enable) begin
               wr_en        = 1'b1;
               wr_tag.first = 1'b1;
               idx_nxt      = IDX_W'(1);
               state_nxt    = S_RUN;
            end
         end
         S_RUN: begin
            if (s_valid) begin
               wr_en        = 1'b1;
               wr_tag.first = (idx == '0);
               if (idx == LAST_IDX) begin
                  wr_tag.last = 1'b1;
                  idx_nxt     = '0;
                  // Only the frame boundary decides whether another frame follows.
                  if (!enable) state_nxt = S_IDLE;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   sync_fifo_fwft_n #(
      .WIDTH (TDATA_WIDTH + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data ({wr_tag, sext}),
      .full    (fifo_full),
      .rd_en   (m_axis_tready),
      .rd_data ({rd_tag, rd_dat}),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = rd_dat;
   assign m_axis_tlast  = rd_tag.last;
   assign m_axis_tuser  = rd_tag.first;
   assign out_fire      = m_axis_tvalid && m_axis_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow    <= 1'b0;
         frame_count <= '0;
      end else begin
         // Full is judged before any same-cycle pop, so the drop stands even if a slot frees up.
         if (wr_en && fifo_full) overflow <= 1'b1;
         if (out_fire && m_axis_tlast) frame_count <= frame_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_sample_stream_framer.sv
module tb_sample_stream_framer;

   localparam int DW = 12;
   localparam int FL = 4;
   localparam int FD = 4;
   localparam int TW = 16;

   typedef struct packed {
      logic          user;
      logic          last;
      logic [TW-1:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic [TW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;
   logic          m_axis_tuser;
   logic          overflow;
   logic [31:0]   frame_count;
   logic [2:0]    fifo_level;

   int    checks = 0;
   int    errors = 0;
   beat_t exp_q[$];
   beat_t obs_q[$];

   always #5 clk = ~clk;

   sample_stream_framer #(
      .DATA_WIDTH (DW),
      .FRAME_LEN  (FL),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .overflow      (overflow),
      .frame_count   (frame_count),
      .fifo_level    (fifo_level)
   );

   // Records every accepted output beat, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready)
         obs_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One source sample for one cycle; consecutive calls give back-to-back valids.
   task automatic push_sample(input logic [DW-1:0] d);
      s_data  = d;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic expect_beat(input logic u, input logic l, input logic [TW-1:0] d);
      exp_q.push_back({u, l, d});
   endtask

   // Waits until the FIFO has drained and every expected beat has been seen.
   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (!m_axis_tvalid && obs_q.size() >= exp_q.size()) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, overflow, m_axis_tdata, frame_count, fifo_level} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: tvalid=%b tlast=%b tuser=%b ovf=%b tdata=%h fc=%0d lvl=%0d, all required 0",
                  m_axis_tvalid, m_axis_tlast, m_axis_tuser, overflow, m_axis_tdata, frame_count, fifo_level);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      bit    ok;
      beat_t e, o;
      enable = 1'b1;
      m_axis_tready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         expect_beat(i == 1 || i == 5, i == 4 || i == 8, TW'(i));
         push_sample(DW'(i));
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout: drain not reached, required within 200 cycles"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL basic_beat missing, required %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL basic_beat got %h required %h", o, e); end
         end
      end
      checks++;
      if (frame_count !== 32'd2 || overflow !== 1'b0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL basic_status fc=%0d ovf=%b extra=%0d, required fc=2 ovf=0 extra=0", frame_count, overflow, obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_sign_ext();
      bit            ok;
      beat_t         e, o;
      logic [DW-1:0] din [4] = '{12'h800, 12'h7FF, 12'hFFF, 12'h001};
      logic [TW-1:0] dout[4] = '{16'hF800, 16'h07FF, 16'hFFFF, 16'h0001};
      for (int i = 0; i < 4; i++) begin
         expect_beat(i == 0, i == 3, dout[i]);
         push_sample(din[i]);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sign_timeout: drain not reached, required within 200 cycles"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL sign_beat missing, required %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL sign_beat got %h required %h", o, e); end
         end
      end
      checks++;
      if (frame_count !== 32'd3) begin errors++; $display("FAIL sign_frame_count got %0d required 3", frame_count); end
      obs_q.delete();
   endtask

   task automatic test_overflow();
      bit    ok;
      beat_t e, o;
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         expect_beat(i == 1, i == 4, TW'(10 + i));
         push_sample(DW'(10 + i));
      end
      checks++;
      if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_fill lvl=%0d ovf=%b, required lvl=4 ovf=0", fifo_level, overflow);
      end
      push_sample(DW'(15));
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b required 1 after 5th sample", overflow); end
      push_sample(DW'(16));
      checks++;
      if (fifo_level !== 3'd4 || m_axis_tdata !== 16'd11 || m_axis_tuser !== 1'b1) begin
         errors++;
         $display("FAIL ovf_hold lvl=%0d tdata=%h tuser=%b, required lvl=4 tdata=000b tuser=1", fifo_level, m_axis_tdata, m_axis_tuser);
      end
      m_axis_tready = 1'b1;
      wait_drain(ok);
      checks++;
      if (!ok || m_axis_tvalid !== 1'b0 || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL ovf_drain ok=%b tvalid=%b lvl=%0d, required ok=1 tvalid=0 lvl=0", ok, m_axis_tvalid, fifo_level);
      end
      // Dropped samples 15,16 still consumed frame slots 0 and 1; 17,18 complete that frame.
      expect_beat(1'b0, 1'b0, TW'(17));
      expect_beat(1'b0, 1'b1, TW'(18));
      push_sample(DW'(17));
      push_sample(DW'(18));
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ovf_timeout: drain not reached, required within 200 cycles"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL ovf_beat missing, required %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL ovf_beat got %h required %h", o, e); end
         end
      end
      checks++;
      if (frame_count !== 32'd5 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_status fc=%0d ovf=%b, required fc=5 ovf=1", frame_count, overflow);
      end
      obs_q.delete();
   endtask

   task automatic test_enable_drop();
      bit    ok;
      beat_t e, o;
      for (int i = 1; i <= 8; i++) begin
         if (i == 3) enable = 1'b0;
         if (i <= 4) expect_beat(i == 1, i == 4, TW'(20 + i));
         push_sample(DW'(20 + i));
      end
      wait_drain(ok);
      checks++;
      if (!ok || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL en_drain ok=%b lvl=%0d, required ok=1 lvl=0", ok, fifo_level);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL en_beat missing, required %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL en_beat got %h required %h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0 || frame_count !== 32'd6) begin
         errors++;
         $display("FAIL en_extra extra=%0d fc=%0d, required extra=0 fc=6", obs_q.size(), frame_count);
      end
      obs_q.delete();
   endtask

   task automatic test_reset_mid_frame();
      bit    ok;
      beat_t e, o;
      enable = 1'b1;
      m_axis_tready = 1'b0;
      push_sample(DW'(31));
      push_sample(DW'(32));
      push_sample(DW'(33));
      checks++;
      if (fifo_level !== 3'd3 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre lvl=%0d ovf=%b, required lvl=3 ovf=1", fifo_level, overflow);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (m_axis_tvalid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0 || frame_count !== 32'd0) begin
         errors++;
         $display("FAIL rstmid_post tvalid=%b lvl=%0d ovf=%b fc=%0d, required all 0", m_axis_tvalid, fifo_level, overflow, frame_count);
      end
      m_axis_tready = 1'b1;
      expect_beat(1'b1, 1'b0, TW'(34));
      push_sample(DW'(34));
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 1'b1 || m_axis_tdata !== 16'd34) begin
         errors++;
         $display("FAIL rstmid_latency tvalid=%b tuser=%b tdata=%h, required 1 1 0022", m_axis_tvalid, m_axis_tuser, m_axis_tdata);
      end
      for (int i = 35; i <= 37; i++) begin
         expect_beat(1'b0, i == 37, TW'(i));
         push_sample(DW'(i));
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_timeout: drain not reached, required within 200 cycles"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL rstmid_beat missing, required %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL rstmid_beat got %h required %h", o, e); end
         end
      end
      obs_q.delete();
   endtask

   task automatic test_gapped_valid();
      bit    ok;
      beat_t e, o;
      for (int i = 0; i < 8; i++) begin
         expect_beat(i % 4 == 0, i % 4 == 3, TW'(41 + i));
         push_sample(DW'(41 + i));
         tick();
         tick();
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL gap_timeout: drain not reached, required within 200 cycles"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL gap_beat missing, required %h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL gap_beat got %h required %h", o, e); end
         end
      end
      checks++;
      if (frame_count !== 32'd3 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL gap_status fc=%0d extra=%0d, required fc=3 extra=0", frame_count, obs_q.size());
      end
      obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sign_ext();
      test_overflow();
      test_enable_drop();
      test_reset_mid_frame();
      test_gapped_valid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
